// File: rtl/cpu_types_pkg.sv
// Shared CPU types: branch predictor entry layout and counter encodings.
package cpu_types_pkg;

  // Default BTB geometry; the entry tag width follows from it.
  localparam int BPRED_ENTRIES_DEFAULT = 16;
  localparam int BPRED_IDX_W_DEFAULT   = $clog2(BPRED_ENTRIES_DEFAULT);
  localparam int BPRED_TAG_W_DEFAULT   = 30 - BPRED_IDX_W_DEFAULT;

  // Reset and allocate encodings for 2-bit saturating counters.
  localparam logic [1:0] BPRED_CTR_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] BPRED_CTR_WNT = 2'b01;  // weakly not-taken

  // One BTB entry at the default geometry.
  typedef struct packed {
    logic                           valid;
    logic [BPRED_TAG_W_DEFAULT-1:0] tag;
    logic [31:0]                    target;
    logic [1:0]                     ctr;
  } bpred_entry_t;

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state function of a CTR_BITS-wide saturating up/down counter.
module bp_sat_ctr #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr_in,
  input  logic                taken,
  output logic [CTR_BITS-1:0] ctr_out
);

  // Count toward taken/not-taken, holding at the end points.
  always_comb begin
    // NOTE: ctr_out gets a default before any branch so no path leaves it unassigned (no latch).
    ctr_out = ctr_in;
    if (taken) begin
      if (ctr_in != '1) ctr_out = ctr_in + 1'b1;
    end else begin
      if (ctr_in != '0) ctr_out = ctr_in - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters.
// Fetch looks up combinationally; execute reports resolved control transfers,
// updating the table and flagging mispredictions.
// Optional BPRED_PERF_EN: adds perf_lookups / perf_mispredicts counters and ports.
module branch_predictor
  import cpu_types_pkg::*;
#(
  parameter int ENTRIES  = BPRED_ENTRIES_DEFAULT,
  parameter int CTR_BITS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_pc,
  output logic        mispredict,
  output logic [31:0] redirect_pc
`ifdef BPRED_PERF_EN
  , output logic [31:0] perf_lookups
  , output logic [31:0] perf_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  // Weakly taken = MSB set, rest clear; weakly not-taken is one below it.
  // With CTR_BITS=1 these become 1 and 0 (a last-outcome bit).
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - 1'b1;

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  logic [IDX_W-1:0]    if_idx;
  logic [TAG_W-1:0]    if_tag;
  logic                lookup_hit;

  logic [IDX_W-1:0]    upd_idx;
  logic [TAG_W-1:0]    upd_tag;
  logic                upd_hit;
  logic [CTR_BITS-1:0] upd_ctr_next;

  // Fetch-side lookup: reads the table as it stands before this cycle's edge.
  assign if_idx     = if_pc[IDX_W+1:2];
  assign if_tag     = if_pc[31:IDX_W+2];
  assign lookup_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken = lookup_hit && ctr_q[if_idx][CTR_BITS-1];
  assign pred_pc    = pred_taken ? target_q[if_idx] : if_pc + 32'd4;

  // Execute-side resolution against what fetch assumed.
  assign upd_idx     = upd_pc[IDX_W+1:2];
  assign upd_tag     = upd_pc[31:IDX_W+2];
  assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign mispredict  = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_pc)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;

  bp_sat_ctr #(.CTR_BITS(CTR_BITS)) u_sat_ctr (
    .ctr_in  (ctr_q[upd_idx]),
    .taken   (upd_taken),
    .ctr_out (upd_ctr_next)
  );

  // Table update: train on hit, allocate on taken miss, ignore not-taken miss.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      // NOTE: the table is reset entry by entry because prediction depends on every valid/ctr
      // being known after reset; this makes it flops rather than a RAM macro.
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (upd_valid) begin
      // NOTE: non-blocking assignments here so lookups this cycle see the old contents.
      if (upd_hit) begin
        ctr_q[upd_idx] <= upd_ctr_next;
        if (upd_taken) target_q[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= CTR_WT;
      end
    end
  end

`ifdef BPRED_PERF_EN
  // Performance counters; both wrap silently.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_lookups     <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (ihit)       perf_lookups     <= perf_lookups + 32'd1;
      if (mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`else
  // ihit only feeds the perf counters, which are not built here.
  logic unused_ihit;
  assign unused_ihit = ihit;
`endif

endmodule
